// File: rtl/instr_issue_ctrl_if.sv
// Issue-slot handshake between the scheduler (master) and the pipeline (slave).
interface issue_if;
    logic       issue_valid;
    logic       issue_ready;
    logic [7:0] issue_instr;
    logic       issue_bubble;

    modport master (
        output issue_valid,
        output issue_instr,
        output issue_bubble,
        input  issue_ready
    );

    modport slave (
        input  issue_valid,
        input  issue_instr,
        input  issue_bubble,
        output issue_ready
    );
endinterface

// File: rtl/instr_issue_ctrl.sv
// Instruction issue controller: button-loaded program memory, in-order issue
// with RAW hazard bubbles (lw-use only with forwarding, full RAW without).
module instr_issue_ctrl #(
    parameter int unsigned N_INSTR = 8,
    parameter int unsigned FWD_EN  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_btn,
    input  logic [7:0]               load_data,
    input  logic                     start,
    issue_if.master                  issue,
    output logic [1:0]               state_o,
    output logic [$clog2(N_INSTR):0] load_count,
    output logic [7:0]               stall_count,
    output logic                     done
);

    localparam int unsigned PCW = $clog2(N_INSTR);
    localparam int unsigned LCW = PCW + 1;

    localparam logic [1:0] OP_LW   = 2'b11;
    localparam logic [1:0] OP_SW   = 2'b10;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_NOOP = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    function automatic logic f_has_dest(input logic [7:0] ins);
        return (ins[7:6] == OP_LW) || (ins[7:6] == OP_ADD);
    endfunction

    function automatic logic f_raw(input logic [7:0] ins, input logic h_vld, input logic [2:0] h_dst);
        logic use_a;
        logic use_b;
        use_a = (ins[7:6] == OP_ADD) || (ins[7:6] == OP_SW);
        use_b = (ins[7:6] != OP_NOOP);
        return h_vld && ((use_a && (ins[5:3] == h_dst)) || (use_b && (ins[2:0] == h_dst)));
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_mem [N_INSTR];
    logic [LCW-1:0]   r_load_count;
    logic             r_btn_q;
    logic [PCW-1:0]   r_pc;
    logic             r_valid;
    logic [7:0]       r_instr;
    logic             r_bubble;
    logic             r_done;
    logic [7:0]       r_stall_count;
    logic             r_h1_vld;
    logic [2:0]       r_h1_dst;
    logic             r_h1_lw;
    logic             r_h2_vld;
    logic [2:0]       r_h2_dst;

    logic             w_rise;
    logic             w_xfer;
    logic             w_last;
    logic             w_wr_en;
    logic             w_wr_restart;
    logic             w_run_start;
    logic [PCW-1:0]   w_wr_idx;
    logic [PCW-1:0]   w_cand_pc;
    logic [7:0]       w_cand;
    logic             w_h1n_vld;
    logic [2:0]       w_h1n_dst;
    logic             w_h1n_lw;
    logic             w_stall;

    assign w_rise    = load_btn & ~r_btn_q;
    assign w_xfer    = r_valid & issue.issue_ready;
    assign w_last    = w_xfer & ~r_bubble & (r_pc == PCW'(N_INSTR - 1));
    assign w_wr_idx  = w_wr_restart ? '0 : r_load_count[PCW-1:0];

    // Dest of the slot now transferring becomes the newest history entry.
    assign w_h1n_vld = ~r_bubble & f_has_dest(r_instr);
    assign w_h1n_dst = r_instr[5:3];
    assign w_h1n_lw  = ~r_bubble & (r_instr[7:6] == OP_LW);
    assign w_cand_pc = r_bubble ? r_pc : r_pc + PCW'(1);
    assign w_cand    = r_mem[w_cand_pc];
    assign w_stall   = (FWD_EN != 0) ? (w_h1n_lw & f_raw(w_cand, w_h1n_vld, w_h1n_dst))
                                     : (f_raw(w_cand, w_h1n_vld, w_h1n_dst) |
                                        f_raw(w_cand, r_h1_vld, r_h1_dst));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and load/run control strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_en      = 1'b0;
        w_wr_restart = 1'b0;
        w_run_start  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_wr_en     = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_rise) begin
                    w_wr_en = 1'b1;
                    if (r_load_count == LCW'(N_INSTR - 1)) w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                if (start) begin
                    w_run_start = 1'b1;
                    w_state_nxt = ST_RUN;
                end else if (w_rise) begin
                    w_wr_en      = 1'b1;
                    w_wr_restart = 1'b1;
                    w_state_nxt  = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (w_last) w_state_nxt = ST_READY;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Program memory; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_en) r_mem[w_wr_idx] <= load_data;
    end

    // Load counter, edge detector, issue slot, hazard history and stall counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_load_count  <= '0;
            r_btn_q       <= 1'b0;
            r_pc          <= '0;
            r_valid       <= 1'b0;
            r_instr       <= 8'h00;
            r_bubble      <= 1'b0;
            r_done        <= 1'b0;
            r_stall_count <= 8'h00;
            r_h1_vld      <= 1'b0;
            r_h1_dst      <= 3'd0;
            r_h1_lw       <= 1'b0;
            r_h2_vld      <= 1'b0;
            r_h2_dst      <= 3'd0;
        end else begin
            r_btn_q <= load_btn;
            r_done  <= 1'b0;
            if (w_wr_en) r_load_count <= w_wr_restart ? LCW'(1) : r_load_count + LCW'(1);
            if (w_run_start) begin
                r_pc          <= '0;
                r_stall_count <= 8'h00;
                r_h1_vld      <= 1'b0;
                r_h1_lw       <= 1'b0;
                r_h2_vld      <= 1'b0;
                r_valid       <= 1'b1;
                r_instr       <= r_mem[0];
                r_bubble      <= 1'b0;
            end else if ((r_state == ST_RUN) && w_xfer) begin
                r_h2_vld <= r_h1_vld;
                r_h2_dst <= r_h1_dst;
                r_h1_vld <= w_h1n_vld;
                r_h1_dst <= w_h1n_dst;
                r_h1_lw  <= w_h1n_lw;
                if (r_bubble && (r_stall_count != 8'hFF)) r_stall_count <= r_stall_count + 8'd1;
                if (w_last) begin
                    r_valid  <= 1'b0;
                    r_instr  <= 8'h00;
                    r_bubble <= 1'b0;
                    r_done   <= 1'b1;
                end else begin
                    r_pc     <= w_cand_pc;
                    r_instr  <= w_stall ? 8'h00 : w_cand;
                    r_bubble <= w_stall;
                end
            end
        end
    end

    assign issue.issue_valid  = r_valid;
    assign issue.issue_instr  = r_instr;
    assign issue.issue_bubble = r_bubble;
    assign state_o            = r_state;
    assign load_count         = r_load_count;
    assign stall_count        = r_stall_count;
    assign done               = r_done;

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Bench for instr_issue_ctrl: one instance with forwarding, one without,
// sharing load/start stimulus; expected issue streams are hand-computed.
module tb_instr_issue_ctrl;

    localparam logic [8:0] BUB = 9'h100;
    localparam int NV = 3;

    typedef struct packed {
        logic [63:0] prog;
        logic [7:0]  n1;
        logic [7:0]  s1;
        logic [7:0]  n0;
        logic [7:0]  s0;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       load_btn;
    logic [7:0] load_data;
    logic       start;
    logic [1:0] st1, st0;
    logic [3:0] lc1, lc0;
    logic [7:0] sc1, sc0;
    logic       dn1, dn0;

    issue_if if1();
    issue_if if0();

    instr_issue_ctrl #(.N_INSTR(8), .FWD_EN(1)) u_dut_fwd (
        .clk(clk), .rst_n(rst_n), .load_btn(load_btn), .load_data(load_data),
        .start(start), .issue(if1), .state_o(st1), .load_count(lc1),
        .stall_count(sc1), .done(dn1)
    );

    instr_issue_ctrl #(.N_INSTR(8), .FWD_EN(0)) u_dut_nofwd (
        .clk(clk), .rst_n(rst_n), .load_btn(load_btn), .load_data(load_data),
        .start(start), .issue(if0), .state_o(st0), .load_count(lc0),
        .stall_count(sc0), .done(dn0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk;
    int          n_fail;
    vec_t        vecs [NV];
    logic [8:0]  exp1 [NV][16];
    logic [8:0]  exp0 [NV][16];
    logic [8:0]  q1 [$];
    logic [8:0]  q0 [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        chk("rst state f1", 32'(st1), 0);
        chk("rst state f0", 32'(st0), 0);
        chk("rst load_count", 32'(lc1), 0);
        chk("rst valid", 32'(if1.issue_valid | if0.issue_valid), 0);
        chk("rst instr", 32'(if1.issue_instr), 0);
        chk("rst bubble", 32'(if1.issue_bubble), 0);
        chk("rst done", 32'(dn1 | dn0), 0);
        chk("rst stall", 32'(sc0), 0);
        rst_n = 1'b1;
    endtask

    task automatic load_byte(input logic [7:0] b);
        load_data = b;
        load_btn  = 1'b1;
        tick();
        load_btn  = 1'b0;
        tick();
    endtask

    task automatic load_prog(input logic [63:0] p);
        for (int i = 0; i < 8; i++) load_byte(p[8*i +: 8]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Run the loaded program with ready held high and compare both streams.
    task automatic run_and_check(input int v, input int rep);
        int d1;
        int d0;
        d1 = 0;
        d0 = 0;
        q1.delete();
        q0.delete();
        pulse_start();
        chk($sformatf("v%0d r%0d first valid f1", v, rep), 32'(if1.issue_valid), 1);
        chk($sformatf("v%0d r%0d first valid f0", v, rep), 32'(if0.issue_valid), 1);
        for (int c = 0; c < 40; c++) begin
            if (if1.issue_valid && if1.issue_ready) q1.push_back({if1.issue_bubble, if1.issue_instr});
            if (if0.issue_valid && if0.issue_ready) q0.push_back({if0.issue_bubble, if0.issue_instr});
            if (dn1) begin
                d1++;
                chk($sformatf("v%0d f1 valid at done", v), 32'(if1.issue_valid), 0);
                chk($sformatf("v%0d f1 state at done", v), 32'(st1), 2);
            end
            if (dn0) begin
                d0++;
                chk($sformatf("v%0d f0 valid at done", v), 32'(if0.issue_valid), 0);
                chk($sformatf("v%0d f0 state at done", v), 32'(st0), 2);
            end
            tick();
        end
        chk($sformatf("v%0d r%0d f1 slot count", v, rep), 32'(q1.size()), 32'(vecs[v].n1));
        chk($sformatf("v%0d r%0d f0 slot count", v, rep), 32'(q0.size()), 32'(vecs[v].n0));
        for (int i = 0; i < int'(vecs[v].n1); i++)
            chk($sformatf("v%0d r%0d f1 slot%0d", v, rep, i),
                (i < q1.size()) ? 32'(q1[i]) : 32'hDEAD, 32'(exp1[v][i]));
        for (int i = 0; i < int'(vecs[v].n0); i++)
            chk($sformatf("v%0d r%0d f0 slot%0d", v, rep, i),
                (i < q0.size()) ? 32'(q0[i]) : 32'hDEAD, 32'(exp0[v][i]));
        chk($sformatf("v%0d r%0d f1 stall", v, rep), 32'(sc1), 32'(vecs[v].s1));
        chk($sformatf("v%0d r%0d f0 stall", v, rep), 32'(sc0), 32'(vecs[v].s0));
        chk($sformatf("v%0d r%0d f1 done pulses", v, rep), 32'(d1), 1);
        chk($sformatf("v%0d r%0d f0 done pulses", v, rep), 32'(d0), 1);
    endtask

    initial begin
        int seen;
        int bad;
        n_chk  = 0;
        n_fail = 0;
        rst_n = 1'b0;
        load_btn = 1'b0;
        load_data = 8'h00;
        start = 1'b0;
        if1.issue_ready = 1'b1;
        if0.issue_ready = 1'b1;

        // lw r1; add r3 <- r3,r1; noops
        vecs[0] = '{prog: 64'h0000_0000_0000_59CA, n1: 8'd9, s1: 8'd1, n0: 8'd10, s0: 8'd2};
        exp1[0] = '{9'h0CA, BUB, 9'h059, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000,
                    9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000};
        exp0[0] = '{9'h0CA, BUB, BUB, 9'h059, 9'h000, 9'h000, 9'h000, 9'h000,
                    9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000};
        // add r1; noop; add r3 <- r3,r1 (distance-two RAW)
        vecs[1] = '{prog: 64'h0000_0000_0059_004A, n1: 8'd8, s1: 8'd0, n0: 8'd9, s0: 8'd1};
        exp1[1] = '{9'h04A, 9'h000, 9'h059, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000,
                    9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000};
        exp0[1] = '{9'h04A, 9'h000, BUB, 9'h059, 9'h000, 9'h000, 9'h000, 9'h000,
                    9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000};
        // lw r0; sw r1,r0; add r2; lw r0; add r0; noop; add r0; noop
        vecs[2] = '{prog: 64'h0040_0040_C352_88C1, n1: 8'd10, s1: 8'd2, n0: 8'd13, s0: 8'd5};
        exp1[2] = '{9'h0C1, BUB, 9'h088, 9'h052, 9'h0C3, BUB, 9'h040, 9'h000,
                    9'h040, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000};
        exp0[2] = '{9'h0C1, BUB, BUB, 9'h088, 9'h052, 9'h0C3, BUB, BUB,
                    9'h040, 9'h000, BUB, 9'h040, 9'h000, 9'h000, 9'h000, 9'h000};

        tick();
        for (int v = 0; v < NV; v++) begin
            do_reset();
            load_prog(vecs[v].prog);
            chk($sformatf("v%0d loaded state", v), 32'(st1), 2);
            chk($sformatf("v%0d loaded count", v), 32'(lc0), 8);
            for (int rep = 0; rep < 2; rep++) run_and_check(v, rep);
        end

        // Backpressure: hold ready low while 59 is presented.
        do_reset();
        load_prog(vecs[0].prog);
        pulse_start();
        chk("bp slot0", 32'({if1.issue_bubble, if1.issue_instr}), 32'h0CA);
        tick();
        chk("bp slot1", 32'({if1.issue_bubble, if1.issue_instr}), 32'(BUB));
        tick();
        chk("bp slot2", 32'({if1.issue_bubble, if1.issue_instr}), 32'h059);
        if1.issue_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("bp hold%0d instr", c), 32'(if1.issue_instr), 32'h59);
            chk($sformatf("bp hold%0d valid", c), 32'(if1.issue_valid), 1);
        end
        if1.issue_ready = 1'b1;
        tick();
        chk("bp after release", 32'({if1.issue_valid, if1.issue_bubble, if1.issue_instr}), 32'h200);
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            if (dn1) seen = 1;
            else tick();
        end
        chk("bp done seen", 32'(seen), 1);
        chk("bp stall", 32'(sc1), 1);

        // Load button level/edge behaviour and restart from READY.
        do_reset();
        load_data = 8'h11;
        load_btn = 1'b1;
        repeat (5) tick();
        chk("held btn count", 32'(lc1), 1);
        chk("held btn state", 32'(st1), 1);
        load_btn = 1'b0;
        tick();
        pulse_start();
        chk("start in LOAD state", 32'(st1), 1);
        chk("start in LOAD valid", 32'(if1.issue_valid), 0);
        for (int i = 0; i < 6; i++) load_byte(8'h00);
        chk("7 edges count", 32'(lc1), 7);
        chk("7 edges state", 32'(st1), 1);
        load_byte(8'h00);
        chk("8th edge count", 32'(lc1), 8);
        chk("8th edge state", 32'(st1), 2);
        load_byte(8'h00);
        chk("9th edge count", 32'(lc1), 1);
        chk("9th edge state", 32'(st1), 1);

        // Reset mid-run, then start must be ignored until a full reload.
        do_reset();
        load_prog(vecs[2].prog);
        pulse_start();
        repeat (4) tick();
        chk("midrun presenting C3", 32'(if1.issue_instr), 32'hC3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrun rst state", 32'(st1), 0);
        chk("midrun rst valid", 32'(if1.issue_valid | if0.issue_valid), 0);
        chk("midrun rst count", 32'(lc1), 0);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (dn1 || dn0 || if1.issue_valid || if0.issue_valid) bad++;
            tick();
        end
        chk("post-rst quiet", 32'(bad), 0);
        pulse_start();
        chk("post-rst start ignored", 32'(st1), 0);
        chk("post-rst start no valid", 32'(if1.issue_valid), 0);
        load_prog(vecs[0].prog);
        chk("reload state", 32'(st0), 2);
        pulse_start();
        chk("reload first slot", 32'({if1.issue_valid, if1.issue_bubble, if1.issue_instr}), 32'h2CA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_issue_ctrl.md
INSTR_ISSUE_CTRL -- requirements
Module: instr_issue_ctrl

Interface
REQ-001 Parameter N_INSTR, default 8, program length in 8-bit instructions; power of two, at least 4.
REQ-002 Parameter FWD_EN, default 1, selects the pipeline hazard model: 1 = forwarding present, 0 = no forwarding.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 load_btn  input  1  load button; a rising edge writes one instruction.
REQ-006 load_data  input  8  instruction byte written on each load_btn rising edge.
REQ-007 start  input  1  begin issuing the loaded program.
REQ-008 issue_ready  input  1  pipeline accepts the current issue slot.
REQ-009 issue_valid  output  1  issue slot present.
REQ-010 issue_instr  output  8  instruction or bubble (8'h00) for the current slot.
REQ-011 issue_bubble  output  1  current slot is a scheduler-inserted stall.
REQ-012 state_o  output  2  state: 0 IDLE, 1 LOAD, 2 READY/DONE-capable, 3 RUN.
REQ-013 load_count  output  log2(N_INSTR)+1  instructions written so far.
REQ-014 stall_count  output  8  bubbles inserted in the last run, saturating at 255.
REQ-015 done  output  1  one-cycle pulse after the last program slot is accepted.

Function
REQ-016 Encoding: [7:6] opcode (11 lw, 10 sw, 01 add, 00 noop), A=[5:3], B=[2:0].
REQ-017 Register use: lw dest A, src B; add dest A, src A and B; sw src A and B, no dest; noop and bubble have no src and no dest.
REQ-018 load_btn passes through a registered edge detector; one write per 0->1 transition; a held level writes once.
REQ-019 IDLE/LOAD: each edge writes load_data to mem[load_count] and increments load_count; first write moves IDLE->LOAD.
REQ-020 The write that makes load_count reach N_INSTR moves to READY; further edges are ignored until READY, and an edge in READY restarts loading at index 0.
REQ-021 start is honoured only in READY and moves to RUN; pc=0, stall_count=0; issue_valid rises the cycle after start is sampled.
REQ-022 start outside READY and load_btn in RUN are ignored.
REQ-023 Issue handshake: a slot transfers when issue_valid&issue_ready; issue_instr and issue_bubble hold stable until the transfer; the next slot is presented the following cycle, giving one slot per cycle under continuous ready.
REQ-024 The scheduler tracks the dest registers of the last two transferred slots; a bubble or noop counts as a slot with no dest.
REQ-025 FWD_EN=1: if the previous slot is lw and its dest matches any src of mem[pc], present one bubble before mem[pc].
REQ-026 FWD_EN=0: RAW on the previous slot -> 2 bubbles; RAW only on the slot before that -> 1 bubble.
REQ-027 Hazard checks are re-evaluated after each bubble transfers, so bubbles are never over-inserted.
REQ-028 Each transferred bubble increments stall_count, saturating at 255; program noops are not counted.
REQ-029 When slot mem[N_INSTR-1] transfers: done pulses for one cycle, issue_valid drops the same cycle, state returns to READY; start re-runs the same program.
REQ-030 History registers clear at RUN entry; the first instruction never stalls.

Reset
REQ-031 rst_n low at a clock edge: state IDLE, load_count 0, pc 0, issue_valid 0, issue_instr 8'h00, issue_bubble 0, done 0, stall_count 0, edge detector and history cleared; mem contents are not cleared.
REQ-032 Reset mid-load or mid-run aborts immediately with no further issue or done; a new full load is required.

Verification
REQ-033 FWD_EN=1, program CA,59 then noops, ready=1 -> slots CA, 00(bubble), 59, noops...; stall_count=1.
REQ-034 FWD_EN=0, same program -> CA, 00b, 00b, 59; stall_count=2.
REQ-035 FWD_EN=0, program 4A,00,59 -> 4A, 00 (program noop, issue_bubble=0), 00b, 59; stall_count=1.
REQ-036 Hold issue_ready low 3 cycles while 59 is presented -> issue_instr stays 59 and issue_valid stays 1; transfer happens on the first ready cycle.
REQ-037 Hold load_btn high for 5 cycles -> load_count +1 only; the 8th edge moves to READY; a 9th edge restarts with load_count=1.
REQ-038 rst_n low for one cycle mid-run at pc=3 -> next cycle IDLE, issue_valid 0, no done pulse; start ignored until a full reload completes.
